// File: rtl/memory_pkg.sv
// memory_pkg: shared pipeline types, funct3 load/store encodings and MEM-stage FSM states.
package memory_pkg;
    localparam int XLEN = 32;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    typedef struct packed {
        logic       enable;
        logic       reg_write;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic       mem_read;
        logic       mem_write;
    } DecodeInfo;
    typedef struct packed {
        logic       stall_req;
        logic [3:0] flush_req;
    } PipeRequest;
    typedef struct packed {
        logic stall;
        logic flush;
    } PipeControl;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} MemState;
endpackage

// File: rtl/memory_if.sv
// memory_if: req/ack data-memory bus between the MEM stage (master) and data memory (slave).
interface memory_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ack;
    logic [31:0] rdata;
    modport master (output req, we, addr, wdata, wstrb, input ack, rdata);
    modport slave (input req, we, addr, wdata, wstrb, output ack, rdata);
endinterface

// File: rtl/memory_align.sv
// mem_align: load byte/half extraction with sign/zero extension, store lane replication and byte strobes.
module mem_align
    import memory_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb
);
    logic [7:0]  b;
    logic [15:0] h;
    logic        sx;
    always_comb begin
        b = 8'(rdata >> {lane, 3'b000});
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        sx = !funct3[2];
        load_data = funct3[1:0] == F3_LW[1:0] ? rdata :
                    funct3[1:0] == F3_LB[1:0] ? {{24{sx & b[7]}}, b} :
                    {{16{sx & h[15]}}, h};
        wdata = funct3[1:0] == F3_SB[1:0] ? {4{store_data[7:0]}} :
                funct3[1:0] == F3_SH[1:0] ? {2{store_data[15:0]}} : store_data;
        wstrb = funct3[1:0] == F3_SB[1:0] ? 4'b0001 << lane :
                funct3[1:0] == F3_SH[1:0] ? 4'b0011 << {lane[1], 1'b0} : 4'b1111;
    end
endmodule

// File: rtl/memory.sv
// memory: rv5stage MEM stage issuing loads/stores on a req/ack bus and registering mem_out/info_ff.
// RV5STAGE_MEM_ALIGN_CHECK_EN: misaligned half/word accesses skip the bus and flag mem_misaligned.
module memory
    import memory_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    output PipeRequest       req,
    input  PipeControl       pipe,
    input  DecodeInfo        info,
    input  logic [XLEN-1:0]  alu_out,
    input  logic [XLEN-1:0]  store_data,
    memory_if.master         dmem,
    output logic [XLEN-1:0]  mem_out,
    output DecodeInfo        info_ff,
    output logic             mem_misaligned
);
    MemState     state;
    logic        flush_pend;
    logic [31:0] cap;
    logic [31:0] load_data;
    logic [31:0] wdata;
    logic [31:0] result;
    logic [3:0]  wstrb;
    logic        access;
    logic        misaligned;
    logic        bus_access;
    logic        done_now;

    mem_align u_align (
        .funct3     (info.funct3),
        .lane       (alu_out[1:0]),
        .rdata      (dmem.rdata),
        .store_data (store_data),
        .load_data  (load_data),
        .wdata      (wdata),
        .wstrb      (wstrb)
    );

    always_comb begin
        access = info.enable && (info.mem_read || info.mem_write);
`ifdef RV5STAGE_MEM_ALIGN_CHECK_EN
        misaligned = access && (info.funct3[1:0] == 2'b01 ? alu_out[0] :
                                info.funct3[1:0] == 2'b10 ? |alu_out[1:0] : 1'b0);
`else
        misaligned = 1'b0;
`endif
        bus_access = access && !misaligned;
        dmem.req = !rst && bus_access && state != DONE;
        dmem.we = bus_access && info.mem_write;
        dmem.addr = {alu_out[31:2], 2'b00};
        dmem.wdata = wdata;
        dmem.wstrb = dmem.we ? wstrb : 4'b0000;
        done_now = dmem.req && dmem.ack;
        req.stall_req = dmem.req && !dmem.ack;
        req.flush_req = 4'b0000;
        result = !info.enable || misaligned ? 32'd0 : info.mem_read ? load_data : alu_out;
    end

    // An issued access cannot be aborted, so a flush seen while waiting is deferred to the ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            flush_pend <= 1'b0;
            cap <= '0;
            mem_out <= '0;
            info_ff <= '0;
            mem_misaligned <= 1'b0;
        end else if (req.stall_req) begin
            state <= BUSY;
            flush_pend <= flush_pend || pipe.flush;
        end else if (done_now && flush_pend) begin
            state <= IDLE;
            flush_pend <= 1'b0;
            mem_out <= '0;
            info_ff <= '0;
            mem_misaligned <= 1'b0;
        end else if (pipe.stall) begin
            if (done_now) begin
                state <= DONE;
                cap <= result;
            end
        end else if (pipe.flush) begin
            state <= IDLE;
            mem_out <= '0;
            info_ff <= '0;
            mem_misaligned <= 1'b0;
        end else begin
            state <= IDLE;
            mem_out <= state == DONE ? cap : result;
            info_ff <= info;
            mem_misaligned <= misaligned;
        end
    end
endmodule

// File: tb/tb_memory.sv
// tb_memory: directed and randomized checks of the MEM stage against a byte-level memory model.
module tb_memory;
    import memory_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    PipeRequest  req;
    PipeControl  pipe;
    DecodeInfo   info;
    DecodeInfo   info_ff;
    logic [31:0] alu_out;
    logic [31:0] store_data;
    logic [31:0] mem_out;
    logic        mem_misaligned;
    logic [7:0]  model [64];
    logic [31:0] bus_mem [16];
    logic [2:0]  load_f3 [5] = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    logic [2:0]  store_f3 [3] = '{F3_SB, F3_SH, F3_SW};
    int checks = 0;
    int errors = 0;
    int txns = 0;

    memory_if dmem ();

    memory dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .pipe           (pipe),
        .info           (info),
        .alu_out        (alu_out),
        .store_data     (store_data),
        .dmem           (dmem),
        .mem_out        (mem_out),
        .info_ff        (info_ff),
        .mem_misaligned (mem_misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic DecodeInfo mk(input logic [2:0] f3, input bit rd_en, input bit wr_en);
        DecodeInfo i;
        i = '0;
        i.enable = 1'b1;
        i.reg_write = !wr_en;
        i.rd = 5'($urandom_range(1, 31));
        i.funct3 = f3;
        i.mem_read = rd_en;
        i.mem_write = wr_en;
        return i;
    endfunction

    function automatic bit mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef RV5STAGE_MEM_ALIGN_CHECK_EN
        return (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
`else
        return (f3 === 3'bxxx) && (a === 32'hx);
`endif
    endfunction

    task automatic preload(input int w, input logic [31:0] v);
        bus_mem[w] = v;
        for (int k = 0; k < 4; k++) model[w * 4 + k] = v[8 * k +: 8];
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int i;
        logic [7:0] b;
        logic [15:0] h;
        if (f3[1:0] == 2'b00) begin
            b = model[a[5:0]];
            return f3[2] ? {24'b0, b} : 32'($signed(b));
        end
        if (f3[1:0] == 2'b01) begin
            i = int'({a[5:1], 1'b0});
            h = {model[i + 1], model[i]};
            return f3[2] ? {16'b0, h} : 32'($signed(h));
        end
        i = int'({a[5:2], 2'b00});
        return {model[i + 3], model[i + 2], model[i + 1], model[i]};
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int n;
        int base;
        n = f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
        base = int'(a[5:0]) & ~(n - 1);
        for (int k = 0; k < n; k++) model[base + k] = d[8 * k +: 8];
    endtask

    // One instruction through the stage: lat wait cycles before ack, hold stalled cycles after it.
    task automatic do_op(input DecodeInfo i, input logic [31:0] a, input logic [31:0] d,
                         input int lat, input int hold, input bit fl);
        bit acc;
        bit m;
        bit bus;
        bit bubble;
        int t0;
        logic [31:0] exp;
        acc = i.enable && (i.mem_read || i.mem_write);
        m = acc && mis(i.funct3, a);
        bus = acc && !m;
        bubble = bus && fl && lat > 1;
        t0 = txns;
        exp = (!i.enable || m) ? 32'd0 : i.mem_read ? ref_load(i.funct3, a) : a;
        info = i;
        alu_out = a;
        store_data = d;
        pipe = '0;
        dmem.ack = 1'b0;
        if (bus) begin
            for (int w = 0; w < lat; w++) begin
                pipe.flush = fl && w == 1;
                #1;
                chk("wait_stall_req", 32'(req.stall_req), 32'd1);
                chk("wait_dmem_req", 32'(dmem.req), 32'd1);
                chk("wait_dmem_addr", dmem.addr, {a[31:2], 2'b00});
                tick;
            end
            pipe.flush = 1'b0;
            pipe.stall = hold > 0;
            dmem.ack = 1'b1;
            dmem.rdata = bus_mem[a[5:2]];
            #1;
            chk("ack_stall_req", 32'(req.stall_req), 32'd0);
            chk("ack_dmem_req", 32'(dmem.req), 32'd1);
            if (dmem.req) txns++;
            if (i.mem_read) chk("load_wstrb", 32'(dmem.wstrb), 32'd0);
            if (i.mem_write) begin
                for (int k = 0; k < 4; k++)
                    if (dmem.wstrb[k]) bus_mem[a[5:2]][8 * k +: 8] = dmem.wdata[8 * k +: 8];
                ref_store(i.funct3, a, d);
            end
            tick;
            dmem.ack = 1'b0;
            for (int h = 0; h < hold; h++) begin
                pipe.stall = h < hold - 1;
                #1;
                chk("done_dmem_req", 32'(dmem.req), 32'd0);
                chk("done_stall_req", 32'(req.stall_req), 32'd0);
                tick;
            end
        end else begin
            #1;
            chk("idle_dmem_req", 32'(dmem.req), 32'd0);
            chk("idle_stall_req", 32'(req.stall_req), 32'd0);
            tick;
        end
        pipe = '0;
        chk("mem_out", mem_out, bubble ? 32'd0 : exp);
        chk("info_ff", {20'b0, info_ff}, bubble ? 32'd0 : {20'b0, i});
        chk("mem_misaligned", 32'(mem_misaligned), bubble ? 32'd0 : 32'(m));
        chk("bus_txns", 32'(txns - t0), 32'(bus));
    endtask

    initial begin
        DecodeInfo si;
        DecodeInfo li;
        info = '0;
        pipe = '0;
        alu_out = '0;
        store_data = '0;
        dmem.ack = 1'b0;
        dmem.rdata = '0;
        for (int w = 0; w < 16; w++) preload(w, $urandom);
        tick;
        tick;
        rst = 1'b0;
        #1;
        chk("rst_mem_out", mem_out, 32'd0);
        chk("rst_info_ff", {20'b0, info_ff}, 32'd0);
        chk("rst_misaligned", 32'(mem_misaligned), 32'd0);
        chk("rst_dmem_req", 32'(dmem.req), 32'd0);
        chk("flush_req", 32'(req.flush_req), 32'd0);

        preload(0, 32'hDEADBEEF);
        do_op(mk(F3_LW, 1, 0), 32'h100, 32'd0, 0, 0, 0);
        chk("lw_value", mem_out, 32'hDEADBEEF);

        preload(0, 32'h80FFFFFF);
        do_op(mk(F3_LB, 1, 0), 32'h103, 32'd0, 0, 0, 0);
        chk("lb_value", mem_out, 32'hFFFFFF80);
        do_op(mk(F3_LBU, 1, 0), 32'h103, 32'd0, 0, 0, 0);
        chk("lbu_value", mem_out, 32'h00000080);

        si = mk(F3_SH, 0, 1);
        info = si;
        alu_out = 32'h202;
        store_data = 32'h1234ABCD;
        #1;
        chk("sh_wdata", dmem.wdata, 32'hABCDABCD);
        chk("sh_wstrb", 32'(dmem.wstrb), 32'hC);
        chk("sh_we", 32'(dmem.we), 32'd1);
        chk("sh_addr", dmem.addr, 32'h200);
        do_op(si, 32'h202, 32'h1234ABCD, 0, 0, 0);
        do_op(mk(F3_LW, 1, 0), 32'h200, 32'd0, 0, 0, 0);

        preload(1, 32'h0BADF00D);
        do_op(mk(F3_LW, 1, 0), 32'h104, 32'd0, 3, 0, 0);
        chk("lw_wait_value", mem_out, 32'h0BADF00D);
        do_op(mk(F3_LW, 1, 0), 32'h104, 32'd0, 0, 3, 0);
        chk("lw_done_value", mem_out, 32'h0BADF00D);
        do_op(mk(F3_SW, 0, 1), 32'h108, 32'hCAFEF00D, 3, 0, 1);
        do_op(mk(F3_LW, 1, 0), 32'h108, 32'd0, 0, 0, 0);
        chk("flushed_store_kept", mem_out, 32'hCAFEF00D);
        do_op(mk(F3_LW, 1, 0), 32'h101, 32'd0, 0, 0, 0);

        li = mk(F3_LW, 1, 0);
        info = li;
        alu_out = 32'h10C;
        #1;
        chk("pre_rst_req", 32'(dmem.req), 32'd1);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        info = '0;
        #1;
        chk("post_rst_req", 32'(dmem.req), 32'd0);
        chk("post_rst_stall", 32'(req.stall_req), 32'd0);
        chk("post_rst_mem_out", mem_out, 32'd0);

        for (int n = 0; n < 200; n++) begin
            int k;
            DecodeInfo ri;
            logic [31:0] a;
            k = $urandom_range(0, 9);
            a = 32'h100 + 32'($urandom_range(0, 63));
            ri = k < 5 ? mk(load_f3[k % 5], 1, 0) : k < 8 ? mk(store_f3[k - 5], 0, 1) :
                 k == 8 ? mk(3'b000, 0, 0) : '0;
            if (k >= 8) a = $urandom;
            do_op(ri, a, $urandom, $urandom_range(0, 3),
                  $urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0, 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
